shift_add_multiplier: RTL and testbench

- Sequential unsigned integer multiplier using the shift-and-add method. It is the inverse-operation companion to the divider's shift-subtract control unit.
- Accepts two WIDTH-bit operands on a go pulse and iterates one multiplier bit per step. It produces a 2*WIDTH-bit product with a one-cycle done pulse.
- It sits beside the divider in the arithmetic unit and shares the same go/done handshake style and debug state output.

---
 rtl/mult_pkg.sv | 13 +
 rtl/shift_add_datapath.sv | 66 ++++++
 rtl/shift_add_multiplier.sv | 67 ++++++
 tb/tb_shift_add_multiplier.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and default width for the arithmetic unit
package mult_pkg;
  localparam int STATE_W       = 3;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_TEST  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/shift_add_datapath.sv
// rtl/shift_add_datapath.sv - A/B/P/cnt registers, accumulator adder and product register
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               add_en_i,
  input  logic               shift_en_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic               b0_o,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] a_q, a_d, p_q, p_d, prod_q, prod_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  assign b0_o      = b_q[0];
  assign last_o    = (cnt_q == CW'(1));
  assign product_o = prod_q;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load_i) begin
      a_d   = {{WIDTH{1'b0}}, x_i};
      b_d   = y_i;
      p_d   = '0;
      cnt_d = CW'(WIDTH);
    end else begin
      if (add_en_i) p_d = p_q + a_q;
      if (shift_en_i) begin
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        // P is final once the last bit's add is done, so capture it on the last shift
        if (last_o) prod_d = p_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add unsigned multiplier with go/done handshake
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy,
  output logic [STATE_W-1:0] CS
);
  state_e cs_q, cs_d;
  logic   load, add_en, shift_en, b0, last;

  shift_add_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (load),
    .add_en_i   (add_en),
    .shift_en_i (shift_en),
    .x_i        (x),
    .y_i        (y),
    .b0_o       (b0),
    .last_o     (last),
    .product_o  (product)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cs_q <= S_IDLE;
    else      cs_q <= cs_d;
  end

  always_comb begin
    cs_d     = cs_q;
    load     = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    case (cs_q)
      S_IDLE: begin
        if (go) begin
          load = 1'b1;
          cs_d = S_TEST;
        end
      end
      S_TEST:  cs_d = b0 ? S_ADD : S_SHIFT;
      S_ADD: begin
        add_en = 1'b1;
        cs_d   = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        cs_d     = last ? S_DONE : S_TEST;
      end
      S_DONE:  cs_d = S_IDLE;
      default: cs_d = S_IDLE;
    endcase
  end

  assign done = (cs_q == S_DONE);
  assign busy = (cs_q != S_IDLE);
  assign CS   = cs_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - directed table-driven bench for shift_add_multiplier
module tb_shift_add_multiplier;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           go  = 1'b0;
  logic [W-1:0]   x   = '0;
  logic [W-1:0]   y   = '0;
  logic [2*W-1:0] product;
  logic           done, busy;
  logic [2:0]     CS;

  int n_chk  = 0;
  int n_fail = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go(go), .x(x), .y(y),
    .product(product), .done(done), .busy(busy), .CS(CS)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xv;
    int yv;
    int prod;
    int lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start an operation and return the number of edges after e0 at which done is seen
  task automatic run_op(input int xa, input int ya, output int n, output bit busy_ok);
    @(negedge clk);
    x  = W'(xa);
    y  = W'(ya);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
  endtask

  vec_t vecs[10];
  int   n;
  bit   bok;
  int   seen_done;
  int   done_at[$];

  initial begin
    vecs[0] = '{6, 5, 30, 10};
    vecs[1] = '{15, 15, 225, 12};
    vecs[2] = '{0, 0, 0, 8};
    vecs[3] = '{1, 1, 1, 9};
    vecs[4] = '{15, 1, 15, 9};
    vecs[5] = '{0, 15, 0, 12};
    vecs[6] = '{8, 8, 64, 9};
    vecs[7] = '{10, 12, 120, 10};
    vecs[8] = '{5, 10, 50, 10};
    vecs[9] = '{1, 15, 15, 12};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(CS), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cs", int'(CS), 0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].xv, vecs[i].yv, n, bok);
      chk($sformatf("v%0d_latency", i), n, vecs[i].lat);
      chk($sformatf("v%0d_product", i), int'(product), vecs[i].prod);
      chk($sformatf("v%0d_busy", i), int'(bok), 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
    end

    // go while busy must be ignored, with new operands presented
    @(negedge clk);
    x = 4'd7; y = 4'd3; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (n < 40) begin
      if (n == 3) begin
        x = 4'd1; y = 4'd1; go = 1'b1;
      end
      @(negedge clk);
      n++;
      go = 1'b0;
      if (done) break;
    end
    chk("ign_latency", n, 10);
    chk("ign_product", int'(product), 21);
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("ign_no_second_done", seen_done, 0);
    chk("ign_product_hold", int'(product), 21);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    x = 4'd9; y = 4'd9; go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mrst_cs", int'(CS), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_product", int'(product), 0);
    chk("mrst_done", int'(done), 0);
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("mrst_no_done", seen_done, 0);
    chk("mrst_product_after", int'(product), 0);
    run_op(2, 3, n, bok);
    chk("post_rst_latency", n, 10);
    chk("post_rst_product", int'(product), 6);

    // go held high: back-to-back operations with one idle cycle between
    @(negedge clk);
    x = 4'd3; y = 4'd2; go = 1'b1;
    n = 0;
    while (n < 60 && done_at.size() < 3) begin
      @(negedge clk);
      n++;
      if (done) begin
        done_at.push_back(n);
        chk($sformatf("held_product%0d", done_at.size()), int'(product), 6);
      end
    end
    go = 1'b0;
    chk("held_done_count", done_at.size(), 3);
    if (done_at.size() == 3) begin
      chk("held_period1", done_at[1] - done_at[0], 11);
      chk("held_period2", done_at[2] - done_at[1], 11);
    end
    repeat (15) @(negedge clk);
    chk("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
